// File: rtl/complex_butterfly_iter_hs_if.sv
// Handshake and data bundle for complex_butterfly_iter_hs.
// The master side drives the operands and out_ready; the slave (the butterfly) returns the results.
interface complex_butterfly_iter_hs_if #(
    parameter int unsigned DWL = 16,
    parameter int unsigned TWL = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [DWL-1:0] a_re;
    logic signed [DWL-1:0] a_im;
    logic signed [DWL-1:0] b_re;
    logic signed [DWL-1:0] b_im;
    logic signed [TWL-1:0] w_re;
    logic signed [TWL-1:0] w_im;
    logic                  scale_in;
    logic                  inv_in;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [DWL-1:0] y1_re;
    logic signed [DWL-1:0] y1_im;
    logic signed [DWL-1:0] y2_re;
    logic signed [DWL-1:0] y2_im;
    logic                  ovf_clr;
    logic                  ovf;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, w_re, w_im, scale_in, inv_in,
        output out_ready, ovf_clr,
        input  in_ready, out_valid, y1_re, y1_im, y2_re, y2_im, ovf
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, w_re, w_im, scale_in, inv_in,
        input  out_ready, ovf_clr,
        output in_ready, out_valid, y1_re, y1_im, y2_re, y2_im, ovf
    );
endinterface

// File: rtl/complex_butterfly_iter_hs.sv
// Radix-2 complex butterfly, one shared multiplier over four cycles, valid/ready handshake.
// Define BFLY_OVF_FLAG_EN to build the sticky saturation flag; otherwise ovf is tied to 0.
module complex_butterfly_iter_hs #(
    parameter int unsigned DWL = 16,
    parameter int unsigned TWL = 16
) (
    input logic                         clk,
    input logic                         rst,
    complex_butterfly_iter_hs_if.slave  bus
);
    localparam int unsigned PW = DWL + TWL;
    localparam int unsigned AW = DWL + TWL + 1;
    localparam int unsigned SW = DWL + TWL + 2;

    localparam logic [SW-1:0]        One    = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] Rnd0   = One << (TWL - 2);
    localparam logic signed [SW-1:0] Rnd1   = One << (TWL - 1);
    localparam logic signed [SW-1:0] SatMax = {{(SW-DWL+1){1'b0}}, {(DWL-1){1'b1}}};
    localparam logic signed [SW-1:0] SatMin = {{(SW-DWL+1){1'b1}}, {(DWL-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StMul0, StMul1, StMul2, StMul3, StAdd, StOut} state_e;

    state_e                state_q;
    logic signed [DWL-1:0] ar_q, ai_q, br_q, bi_q;
    logic signed [TWL-1:0] wr_q, wi_q;
    logic                  scale_q, inv_q;
    logic signed [AW-1:0]  acc_re_q, acc_im_q;
    logic signed [DWL-1:0] y1_re_q, y1_im_q, y2_re_q, y2_im_q;
    logic                  out_valid_q;

    logic                  in_ready;
    logic                  accept;
    logic signed [DWL-1:0] mul_a;
    logic signed [TWL-1:0] mul_b;
    logic                  sel_im;
    logic                  neg;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  term;
    logic signed [SW-1:0]  br_al, bi_al, acc_re_ext, acc_im_ext;
    logic signed [SW-1:0]  s1_re, s1_im, s2_re, s2_im;

    function automatic logic signed [SW-1:0] round_shift(input logic signed [SW-1:0] s,
                                                         input logic sc);
        if (sc) return (s + Rnd1) >>> TWL;
        else    return (s + Rnd0) >>> (TWL - 1);
    endfunction

    function automatic logic signed [DWL-1:0] round_sat(input logic signed [SW-1:0] s,
                                                        input logic sc);
        logic signed [SW-1:0] q;
        q = round_shift(s, sc);
        if (q > SatMax)      return SatMax[DWL-1:0];
        else if (q < SatMin) return SatMin[DWL-1:0];
        else                 return q[DWL-1:0];
    endfunction

    assign in_ready = (state_q == StIdle) || ((state_q == StOut) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // Product schedule: ar*wr, ai*wi, ar*wi, ai*wr; inv flips the sign of the wi terms.
    always_comb begin
        mul_a  = ar_q;
        mul_b  = wr_q;
        sel_im = 1'b0;
        neg    = 1'b0;
        case (state_q)
            StMul1: begin mul_a = ai_q; mul_b = wi_q; neg = !inv_q; end
            StMul2: begin mul_a = ar_q; mul_b = wi_q; neg = inv_q; sel_im = 1'b1; end
            StMul3: begin mul_a = ai_q; mul_b = wr_q; sel_im = 1'b1; end
            default: ;
        endcase
    end

    assign prod     = PW'(mul_a) * PW'(mul_b);
    assign prod_ext = AW'(prod);
    assign term     = neg ? -prod_ext : prod_ext;

    assign br_al      = SW'(br_q) <<< (TWL - 1);
    assign bi_al      = SW'(bi_q) <<< (TWL - 1);
    assign acc_re_ext = SW'(acc_re_q);
    assign acc_im_ext = SW'(acc_im_q);
    assign s1_re      = br_al + acc_re_ext;
    assign s1_im      = bi_al + acc_im_ext;
    assign s2_re      = br_al - acc_re_ext;
    assign s2_im      = bi_al - acc_im_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ar_q        <= '0;
            ai_q        <= '0;
            br_q        <= '0;
            bi_q        <= '0;
            wr_q        <= '0;
            wi_q        <= '0;
            scale_q     <= 1'b0;
            inv_q       <= 1'b0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            y1_re_q     <= '0;
            y1_im_q     <= '0;
            y2_re_q     <= '0;
            y2_im_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StOut: begin
                    if ((state_q == StOut) && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                    if (accept) begin
                        ar_q     <= bus.a_re;
                        ai_q     <= bus.a_im;
                        br_q     <= bus.b_re;
                        bi_q     <= bus.b_im;
                        wr_q     <= bus.w_re;
                        wi_q     <= bus.w_im;
                        scale_q  <= bus.scale_in;
                        inv_q    <= bus.inv_in;
                        acc_re_q <= '0;
                        acc_im_q <= '0;
                        state_q  <= StMul0;
                    end
                end
                StMul0, StMul1, StMul2, StMul3: begin
                    if (sel_im) acc_im_q <= acc_im_q + term;
                    else        acc_re_q <= acc_re_q + term;
                    state_q <= (state_q == StMul3) ? StAdd : state_e'(state_q + 3'd1);
                end
                StAdd: begin
                    y1_re_q     <= round_sat(s1_re, scale_q);
                    y1_im_q     <= round_sat(s1_im, scale_q);
                    y2_re_q     <= round_sat(s2_re, scale_q);
                    y2_im_q     <= round_sat(s2_im, scale_q);
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef BFLY_OVF_FLAG_EN
    function automatic logic is_sat(input logic signed [SW-1:0] s, input logic sc);
        logic signed [SW-1:0] q;
        q = round_shift(s, sc);
        return (q > SatMax) || (q < SatMin);
    endfunction

    logic ovf_q;
    logic any_sat;

    assign any_sat = is_sat(s1_re, scale_q) || is_sat(s1_im, scale_q) ||
                     is_sat(s2_re, scale_q) || is_sat(s2_im, scale_q);

    // Set has priority over clear.
    always_ff @(posedge clk) begin
        if (rst)                               ovf_q <= 1'b0;
        else if ((state_q == StAdd) && any_sat) ovf_q <= 1'b1;
        else if (bus.ovf_clr)                  ovf_q <= 1'b0;
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y1_re     = y1_re_q;
    assign bus.y1_im     = y1_im_q;
    assign bus.y2_re     = y2_re_q;
    assign bus.y2_im     = y2_im_q;
endmodule

// File: tb/tb_complex_butterfly_iter_hs.sv
// Directed bench for complex_butterfly_iter_hs with hand-computed Q1.15 results.
// Expected ovf follows BFLY_OVF_FLAG_EN the same way the build does.
module tb_complex_butterfly_iter_hs;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef BFLY_OVF_FLAG_EN
    localparam logic [15:0] OvfOn = 16'd1;
`else
    localparam logic [15:0] OvfOn = 16'd0;
`endif

    complex_butterfly_iter_hs_if #(.DWL(16), .TWL(16)) bus ();

    complex_butterfly_iter_hs #(.DWL(16), .TWL(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] ar, input logic [15:0] ai, input logic [15:0] br,
                         input logic [15:0] bi, input logic [15:0] wr, input logic [15:0] wi,
                         input logic sc, input logic inv);
        bus.a_re = ar; bus.a_im = ai; bus.b_re = br; bus.b_im = bi;
        bus.w_re = wr; bus.w_im = wi; bus.scale_in = sc; bus.inv_in = inv;
    endtask

    // Count edges after the accept edge until out_valid, bounded.
    task automatic wait_result(input string tag);
        int lat = 0;
        drive(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h1357, 16'h2468, 1'b1, 1'b1);
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check(tag, 16'(lat), 16'd5);
    endtask

    task automatic run_op(input string tag, input logic [15:0] ar, input logic [15:0] ai,
                          input logic [15:0] br, input logic [15:0] bi, input logic [15:0] wr,
                          input logic [15:0] wi, input logic sc, input logic inv);
        drive(ar, ai, br, bi, wr, wi, sc, inv);
        bus.in_valid = 1'b1;
        check({tag, "_in_ready"}, 16'(bus.in_ready), 16'd1);
        tick();
        bus.in_valid = 1'b0;
        wait_result({tag, "_lat"});
    endtask

    task automatic check_y(input string tag, input logic [15:0] e1r, input logic [15:0] e1i,
                           input logic [15:0] e2r, input logic [15:0] e2i);
        check({tag, "_y1_re"}, bus.y1_re, e1r);
        check({tag, "_y1_im"}, bus.y1_im, e1i);
        check({tag, "_y2_re"}, bus.y2_re, e2r);
        check({tag, "_y2_im"}, bus.y2_im, e2i);
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic stuck;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        drive(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

        tick();
        tick();
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_y1_re", bus.y1_re, 16'h0000);
        check("rst_ovf", 16'(bus.ovf), 16'd0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", 16'(bus.in_ready), 16'd1);

        // 0.5 * ~1.0 + 0.25
        run_op("basic", 16'h4000, 16'h0, 16'h2000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0);
        check_y("basic", 16'h6000, 16'h0000, 16'hE001, 16'h0000);
        pop();
        check("basic_pop_valid", 16'(bus.out_valid), 16'd0);

        run_op("satp", 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0);
        check("satp_y1_re", bus.y1_re, 16'h7FFF);
        check("satp_y2_re", bus.y2_re, 16'h0001);
        check("satp_ovf", 16'(bus.ovf), OvfOn);
        pop();

        run_op("sc1", 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 1'b1, 1'b0);
        check("sc1_y1_re", bus.y1_re, 16'h7FFF);
        check("sc1_y2_re", bus.y2_re, 16'h0000);
        check("sc1_ovf", 16'(bus.ovf), OvfOn);
        pop();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", 16'(bus.ovf), 16'd0);

        run_op("jj", 16'h0, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h4000, 1'b0, 1'b0);
        check_y("jj", 16'hE000, 16'h0000, 16'h2000, 16'h0000);
        pop();
        run_op("jjinv", 16'h0, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h4000, 1'b0, 1'b1);
        check_y("jjinv", 16'h2000, 16'h0000, 16'hE000, 16'h0000);
        pop();

        // -1 + ~1.0 rounds to -2 LSB; -1 - ~1.0 saturates low
        run_op("satn", 16'h7FFF, 16'h0, 16'h8000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0);
        check_y("satn", 16'hFFFE, 16'h0000, 16'h8000, 16'h0000);
        check("satn_ovf", 16'(bus.ovf), OvfOn);
        pop();

        run_op("mix", 16'h2000, 16'h1000, 16'h0100, 16'h0200, 16'h4000, 16'h2000, 1'b1, 1'b0);
        check_y("mix", 16'h0680, 16'h0900, 16'hFA80, 16'hF900);
        pop();

        // Back-pressure, then accept on the same edge as the pop
        run_op("bp", 16'h4000, 16'h0, 16'h2000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0);
        stuck = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.out_valid || bus.y1_re !== 16'h6000 || bus.y2_re !== 16'hE001 ||
                bus.in_ready) stuck = 1'b0;
        end
        check("bp_hold", 16'(stuck), 16'd1);
        drive(16'h0, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h4000, 1'b0, 1'b0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready", 16'(bus.in_ready), 16'd1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("bp_valid_drop", 16'(bus.out_valid), 16'd0);
        wait_result("bp_next_lat");
        check_y("bp_next", 16'hE000, 16'h0000, 16'h2000, 16'h0000);
        pop();

        // Reset while in MUL2 discards the operation
        drive(16'h4000, 16'h0, 16'h2000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_out_valid", 16'(bus.out_valid), 16'd0);
        check("mrst_y1_re", bus.y1_re, 16'h0000);
        check("mrst_y2_re", bus.y2_re, 16'h0000);
        check("mrst_in_ready", 16'(bus.in_ready), 16'd1);
        stuck = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) stuck = 1'b1;
        end
        check("mrst_no_valid", 16'(stuck), 16'd0);

        // Clear held through a saturating ADD: set wins
        bus.ovf_clr = 1'b1;
        run_op("setclr", 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 1'b0, 1'b0);
        check("setclr_ovf", 16'(bus.ovf), OvfOn);
        bus.ovf_clr = 1'b0;
        pop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
